sha256_core_arbiter: RTL and testbench

// Shares one sha256XMSS hash core between NUM_REQ hash clients (thash_f, thash_h, PRF, ...).

---
 rtl/sha256_core_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sha256_core_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core between NUM_REQ hash clients.
// Operands are steered combinationally by grant_idx; done and digest return to the granted client.
module sha256_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int KEY_LEN = 256,
    parameter int DATA_W  = 1024,
    parameter int IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]        req_msg_len,
    input  logic [NUM_REQ-1:0]        req_cont,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [KEY_LEN-1:0]        req_data_out,
    output logic                      hash_start,
    output logic [DATA_W-1:0]         hash_data_in,
    output logic                      message_length,
    output logic                      continue_intermediate,
    input  logic                      hash_done,
    input  logic [KEY_LEN-1:0]        hash_data_out,
    output logic [IDX_W-1:0]          grant_idx,
    output logic [31:0]               busy_cycles,
    output logic                      proto_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pend_nxt;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] start_ok;
    logic [NUM_REQ-1:0] start_bad;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_pick;
    logic               rr_found;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_len;
    logic               sel_cont;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        return (int'(v) == NUM_REQ - 1) ? '0 : v + IDX_W'(1);
    endfunction

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (grant_idx == IDX_W'(i));
        end
    end

    // Round-robin scan: first pending client at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0] j;
        rr_pick  = rr_ptr;
        rr_found = 1'b0;
        j        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (j >= (IDX_W+1)'(NUM_REQ)) begin
                j = j - (IDX_W+1)'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!rr_found && pending[i] && (j == (IDX_W+1)'(i))) begin
                    rr_pick  = IDX_W'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end

    // A start from an already-pending client, or from the client currently in service, is rejected.
    always_comb begin
        start_ok  = '0;
        start_bad = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start[i]) begin
                if (pending[i] || ((state != IDLE) && grant_oh[i])) begin
                    start_bad[i] = 1'b1;
                end else begin
                    start_ok[i] = 1'b1;
                end
            end
        end
        pend_nxt = pending | start_ok;
        if (state == ISSUE) begin
            pend_nxt = pend_nxt & ~grant_oh;
        end
    end

    always_comb begin
        sel_data = '0;
        sel_len  = 1'b0;
        sel_cont = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_data = req_data_in[i*DATA_W +: DATA_W];
                sel_len  = req_msg_len[i];
                sel_cont = req_cont[i];
            end
        end
    end

    // Core-side operands are forced to zero while reset is held so every output reads 0.
    assign hash_data_in          = reset ? sel_data : '0;
    assign message_length        = reset & sel_len;
    assign continue_intermediate = reset & sel_cont;
    assign req_busy              = pending | ((state != IDLE) ? grant_oh : '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pending      <= '0;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            busy_cycles  <= '0;
            proto_err    <= 1'b0;
            hash_start   <= 1'b0;
            req_done     <= '0;
            req_data_out <= '0;
        end else begin
            pending    <= pend_nxt;
            hash_start <= 1'b0;
            req_done   <= '0;
            if (|start_bad) begin
                proto_err <= 1'b1;
            end
            if ((state == ISSUE) || (state == WAIT)) begin
                busy_cycles <= sat_inc(busy_cycles);
            end
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        grant_idx  <= rr_pick;
                        hash_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (hash_done) begin
                        req_data_out <= hash_data_out;
                        req_done     <= grant_oh;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= wrap_inc(grant_idx);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a fixed-latency core model and a digest scoreboard.
module tb_sha256_core_arbiter;

    localparam int NUM_REQ = 4;
    localparam int KEY_LEN = 256;
    localparam int DATA_W  = 1024;
    localparam int IDX_W   = 3;
    localparam int LAT     = 20;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_start;
    logic [NUM_REQ*DATA_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]        req_msg_len;
    logic [NUM_REQ-1:0]        req_cont;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_busy;
    logic [KEY_LEN-1:0]        req_data_out;
    logic                      hash_start;
    logic [DATA_W-1:0]         hash_data_in;
    logic                      message_length;
    logic                      continue_intermediate;
    logic                      hash_done = 1'b0;
    logic [KEY_LEN-1:0]        hash_data_out = '0;
    logic [IDX_W-1:0]          grant_idx;
    logic [31:0]               busy_cycles;
    logic                      proto_err;

    sha256_core_arbiter #(
        .NUM_REQ(NUM_REQ),
        .KEY_LEN(KEY_LEN),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_start            (req_start),
        .req_data_in          (req_data_in),
        .req_msg_len          (req_msg_len),
        .req_cont             (req_cont),
        .req_done             (req_done),
        .req_busy             (req_busy),
        .req_data_out         (req_data_out),
        .hash_start           (hash_start),
        .hash_data_in         (hash_data_in),
        .message_length       (message_length),
        .continue_intermediate(continue_intermediate),
        .hash_done            (hash_done),
        .hash_data_out        (hash_data_out),
        .grant_idx            (grant_idx),
        .busy_cycles          (busy_cycles),
        .proto_err            (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 client;
        logic [KEY_LEN-1:0] dig;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   hs_count    = 0;
    int   done_count [NUM_REQ];
    int   exp_busy    = 0;
    int   cyc         = 0;
    int   done_cyc    = -10;
    int   core_cnt    = 0;
    logic [KEY_LEN-1:0] core_dig = '0;
    logic hs_prev = 1'b0;

    function automatic logic [KEY_LEN-1:0] model_digest(input logic [DATA_W-1:0] d,
                                                        input logic ml, input logic ct);
        logic [KEY_LEN-1:0] acc;
        acc = {ml, ct, 254'h0} ^ 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
        for (int c = 0; c < DATA_W / KEY_LEN; c++) begin
            acc = {acc[KEY_LEN-2:0], acc[KEY_LEN-1]} ^ d[c*KEY_LEN +: KEY_LEN];
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [KEY_LEN-1:0] obs, input logic [KEY_LEN-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: fixed latency from the sampled hash_start to a one-cycle hash_done.
    always @(negedge clk) begin
        hash_done = 1'b0;
        if (!reset) begin
            core_cnt = 0;
        end else if (hash_start) begin
            core_cnt = LAT;
            core_dig = model_digest(hash_data_in, message_length, continue_intermediate);
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                hash_done     = 1'b1;
                hash_data_out = core_dig;
                done_cyc      = cyc;
            end
        end
    end

    // Response monitor: pops the scoreboard on every req_done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (hash_start) begin
                hs_count++;
                check("hs_one_cycle", KEY_LEN'(hs_prev), '0);
            end
            if (req_done != '0) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_done[i]) done_count[i]++;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_done", KEY_LEN'(req_done), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_client", KEY_LEN'(req_done), KEY_LEN'(1) << e.client);
                    check("done_digest", req_data_out, e.dig);
                    check("done_latency", KEY_LEN'(cyc), KEY_LEN'(done_cyc + 1));
                end
            end
            hs_prev = hash_start;
        end else begin
            hs_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [NUM_REQ-1:0] m);
        req_start = m;
        @(posedge clk);
        #1;
        req_start = '0;
    endtask

    task automatic set_operands();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int w = 0; w < DATA_W / 32; w++) begin
                req_data_in[i*DATA_W + w*32 +: 32] = $urandom();
            end
        end
        req_msg_len = NUM_REQ'($urandom());
        req_cont    = NUM_REQ'($urandom());
    endtask

    task automatic push_exp(input int c);
        exp_t e;
        e.client = c;
        e.dig    = model_digest(req_data_in[c*DATA_W +: DATA_W], req_msg_len[c], req_cont[c]);
        exp_q.push_back(e);
        exp_busy += LAT + 1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((req_busy != '0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle_timeout", KEY_LEN'(n >= budget), '0);
    endtask

    function automatic int total_done();
        int s;
        s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += done_count[i];
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int d0;
        for (int i = 0; i < NUM_REQ; i++) done_count[i] = 0;
        reset     = 1'b0;
        req_start = '0;
        set_operands();
        tick(3);
        check("rst_hash_start", KEY_LEN'(hash_start), '0);
        check("rst_req_done", KEY_LEN'(req_done), '0);
        check("rst_req_data_out", req_data_out, '0);
        check("rst_hash_data_in", KEY_LEN'(hash_data_in != '0), '0);
        check("rst_grant_idx", KEY_LEN'(grant_idx), '0);
        check("rst_busy_cycles", KEY_LEN'(busy_cycles), '0);
        check("rst_proto_err", KEY_LEN'(proto_err), '0);
        check("rst_req_busy", KEY_LEN'(req_busy), '0);
        reset = 1'b1;
        tick(1);

        // Single client 0, uncontended.
        push_exp(0);
        pulse_start(4'b0001);
        check("t1_pending", KEY_LEN'(req_busy), KEY_LEN'(4'b0001));
        check("t1_no_hs_yet", KEY_LEN'(hash_start), '0);
        tick(1);
        check("t1_hs", KEY_LEN'(hash_start), KEY_LEN'(1));
        check("t1_grant", KEY_LEN'(grant_idx), '0);
        check("t1_operands", KEY_LEN'(hash_data_in == req_data_in[0 +: DATA_W]), KEY_LEN'(1));
        wait_idle(100);
        check("t1_done_count", KEY_LEN'(done_count[0]), KEY_LEN'(1));
        check("t1_busy_cycles", KEY_LEN'(busy_cycles), KEY_LEN'(exp_busy));
        check("t1_proto_err", KEY_LEN'(proto_err), '0);

        // All four clients at once from a fresh rr_ptr.
        reset = 1'b0;
        tick(2);
        reset    = 1'b1;
        exp_busy = 0;
        tick(1);
        set_operands();
        for (int c = 0; c < NUM_REQ; c++) push_exp(c);
        pulse_start(4'b1111);
        wait_idle(400);
        check("t2_busy_cycles", KEY_LEN'(busy_cycles), KEY_LEN'(exp_busy));
        check("t2_total_done", KEY_LEN'(total_done()), KEY_LEN'(5));
        check("t2_proto_err", KEY_LEN'(proto_err), '0);

        // After serving client 1, client 3 precedes client 0.
        set_operands();
        push_exp(1);
        pulse_start(4'b0010);
        wait_idle(100);
        push_exp(3);
        push_exp(0);
        pulse_start(4'b1001);
        wait_idle(200);
        check("t3_busy_cycles", KEY_LEN'(busy_cycles), KEY_LEN'(exp_busy));

        // Client 1 restarts while pending and again while in WAIT.
        hs0 = hs_count;
        d0  = done_count[1];
        push_exp(1);
        pulse_start(4'b0010);
        pulse_start(4'b0010);
        tick(4);
        pulse_start(4'b0010);
        wait_idle(100);
        check("t4_proto_err", KEY_LEN'(proto_err), KEY_LEN'(1));
        check("t4_hs_count", KEY_LEN'(hs_count - hs0), KEY_LEN'(1));
        check("t4_done_count", KEY_LEN'(done_count[1] - d0), KEY_LEN'(1));

        // Reset in WAIT with two more requests pending.
        pulse_start(4'b0111);
        tick(6);
        check("t5_in_wait_busy", KEY_LEN'(req_busy), KEY_LEN'(4'b0111));
        hs0   = hs_count;
        d0    = total_done();
        reset = 1'b0;
        #1;
        check("t5_hash_start", KEY_LEN'(hash_start), '0);
        check("t5_req_busy", KEY_LEN'(req_busy), '0);
        check("t5_grant_idx", KEY_LEN'(grant_idx), '0);
        check("t5_busy_cycles", KEY_LEN'(busy_cycles), '0);
        check("t5_proto_err", KEY_LEN'(proto_err), '0);
        check("t5_req_data_out", req_data_out, '0);
        check("t5_core_side", KEY_LEN'({hash_data_in != '0, message_length, continue_intermediate}), '0);
        tick(2);
        reset    = 1'b1;
        exp_busy = 0;
        tick(40);
        check("t5_no_hs_after", KEY_LEN'(hs_count - hs0), '0);
        check("t5_no_done_after", KEY_LEN'(total_done() - d0), '0);
        check("t5_idle_busy", KEY_LEN'(req_busy), '0);
        push_exp(0);
        pulse_start(4'b0001);
        wait_idle(100);
        check("t5_recover_busy", KEY_LEN'(busy_cycles), KEY_LEN'(exp_busy));

        // Three back-to-back jobs.
        set_operands();
        push_exp(1);
        push_exp(2);
        push_exp(3);
        pulse_start(4'b1110);
        wait_idle(300);
        check("t6_busy_cycles", KEY_LEN'(busy_cycles), KEY_LEN'(exp_busy));
        check("t6_proto_err", KEY_LEN'(proto_err), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
